serial_frame_tx: RTL and testbench

Parallel-in, serial-out frame transmitter. It is the sending end of the team's flip-flop-based serial receiver path.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Latches the word into an internal shift register.
- Drives one line as: start bit, data LSB first, optional even parity, stop bit.
- Each bit is held for CLKS_PER_BIT clocks.
- Sits between a producer (register file or controller) and the serial line.

---
 rtl/serial_pkg.sv | 29 ++
 rtl/serial_frame_tx_bit_timer.sv | 50 +++++
 rtl/serial_frame_tx.sv | 167 ++++++++++++++++
 tb/tb_serial_frame_tx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial line path (transmitter and receiver).
//   state_e      : frame sequencer states, 3-bit encoding
//   LINE_IDLE    : level of the line between frames
//   START_BIT    : level of the start bit
//   STOP_BIT     : level of the stop bit
//   even_parity  : parity bit that makes the count of ones even
// -----------------------------------------------------------------------------
package serial_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Narrower words are zero-extended by the caller; zeros do not change the result.
   function automatic logic even_parity(input logic [31:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// -----------------------------------------------------------------------------
// bit_timer
// Divides the clock into bit periods of CLKS_PER_BIT cycles.
//   clk  : system clock, rising-edge active
//   rst  : asynchronous, active-low reset
//   run  : count while high; counter held at zero while low
//   tick : high on the last cycle of each bit period
// -----------------------------------------------------------------------------
module bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic tick
);

   // A one-cycle bit period still needs a 1-bit counter to keep the vectors legal.
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nx;

   // Next count: clear when idle, wrap at the end of a bit period.
   always_comb begin
      w_cnt_nx = r_cnt;
      if (!run) begin
         w_cnt_nx = CNT_ZERO;
      end else if (r_cnt == CNT_LAST) begin
         w_cnt_nx = CNT_ZERO;
      end else begin
         w_cnt_nx = r_cnt + CNT_ONE;
      end
   end

   // Cycle counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= CNT_ZERO;
      end else begin
         r_cnt <= w_cnt_nx;
      end
   end

   assign tick = run && (r_cnt == CNT_LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// -----------------------------------------------------------------------------
// serial_frame_tx
// Parallel-in, serial-out frame transmitter: start bit, data LSB first,
// optional even parity, stop bit; each bit held CLKS_PER_BIT clocks.
//   clk        : system clock, rising-edge active
//   rst        : asynchronous, active-low reset
//   data_in    : word to transmit, sampled only on handshake
//   load_valid : producer has a word on data_in
//   load_ready : transmitter can accept a word this cycle (state is IDLE)
//   sout       : serial line, idles high (registered)
//   busy       : frame in progress (registered)
//   done       : one-cycle pulse in the first IDLE cycle after a stop bit
// -----------------------------------------------------------------------------
module serial_frame_tx
   import serial_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   localparam int BW = $clog2(WIDTH + 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [BW-1:0] BIT_ONE  = BW'(32'd1);
   localparam logic [BW-1:0] BIT_ZERO = {BW{1'b0}};

   state_e           r_state, w_state_nx;
   logic [WIDTH-1:0] r_shreg, w_shreg_nx;
   logic [BW-1:0]    r_bitcnt, w_bitcnt_nx;
   logic             r_par, w_par_nx;
   logic             r_sout, w_sout_nx;
   logic             r_busy, w_busy_nx;
   logic             r_done, w_done_nx;
   logic             w_run;
   logic             w_tick;

   assign w_run = (r_state != IDLE);

   bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk  (clk),
      .rst  (rst),
      .run  (w_run),
      .tick (w_tick)
   );

   // Next-state and next-output logic; sout is loaded one bit ahead so it
   // changes on the same edge as the state.
   always_comb begin
      w_state_nx  = r_state;
      w_shreg_nx  = r_shreg;
      w_bitcnt_nx = r_bitcnt;
      w_par_nx    = r_par;
      w_sout_nx   = r_sout;
      w_busy_nx   = r_busy;
      w_done_nx   = 1'b0;
      case (r_state)
         IDLE: begin
            w_sout_nx = LINE_IDLE;
            w_busy_nx = 1'b0;
            if (load_valid) begin
               w_state_nx  = START;
               w_shreg_nx  = data_in;
               w_par_nx    = even_parity(32'(data_in));
               w_bitcnt_nx = BIT_ZERO;
               w_sout_nx   = START_BIT;
               w_busy_nx   = 1'b1;
            end else begin
               w_state_nx = IDLE;
            end
         end
         START: begin
            if (w_tick) begin
               w_state_nx = DATA;
               w_sout_nx  = r_shreg[0];
               w_shreg_nx = r_shreg >> 1'b1;
            end else begin
               w_sout_nx = START_BIT;
            end
         end
         DATA: begin
            if (w_tick) begin
               if (r_bitcnt == BIT_LAST) begin
                  w_bitcnt_nx = BIT_ZERO;
                  if (PARITY_EN != 0) begin
                     w_state_nx = PARITY;
                     w_sout_nx  = r_par;
                  end else begin
                     w_state_nx = STOP;
                     w_sout_nx  = STOP_BIT;
                  end
               end else begin
                  w_bitcnt_nx = r_bitcnt + BIT_ONE;
                  w_sout_nx   = r_shreg[0];
                  w_shreg_nx  = r_shreg >> 1'b1;
               end
            end else begin
               w_bitcnt_nx = r_bitcnt;
            end
         end
         PARITY: begin
            if (w_tick) begin
               w_state_nx = STOP;
               w_sout_nx  = STOP_BIT;
            end else begin
               w_sout_nx = r_par;
            end
         end
         STOP: begin
            if (w_tick) begin
               w_state_nx = IDLE;
               w_sout_nx  = LINE_IDLE;
               w_busy_nx  = 1'b0;
               w_done_nx  = 1'b1;
            end else begin
               w_sout_nx = STOP_BIT;
            end
         end
         default: begin
            // Illegal encoding: recover to a quiet line.
            w_state_nx  = IDLE;
            w_shreg_nx  = {WIDTH{1'b0}};
            w_bitcnt_nx = BIT_ZERO;
            w_par_nx    = 1'b0;
            w_sout_nx   = LINE_IDLE;
            w_busy_nx   = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_shreg  <= {WIDTH{1'b0}};
         r_bitcnt <= BIT_ZERO;
         r_par    <= 1'b0;
         r_sout   <= LINE_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_shreg  <= w_shreg_nx;
         r_bitcnt <= w_bitcnt_nx;
         r_par    <= w_par_nx;
         r_sout   <= w_sout_nx;
         r_busy   <= w_busy_nx;
         r_done   <= w_done_nx;
      end
   end

   assign load_ready = (r_state == IDLE);
   assign sout       = r_sout;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule

// File: tb/tb_serial_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_tx
// Directed bench for serial_frame_tx. Instance A uses the default parameters;
// instance B uses CLKS_PER_BIT=1 and no parity bit. Expected line patterns are
// written as {stop, parity, data[7:0], start}, bit 0 transmitted first.
// -----------------------------------------------------------------------------
module tb_serial_frame_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic [7:0] data_in_a = 8'h00;
   logic       load_valid_a = 1'b0;
   logic       load_ready_a, sout_a, busy_a, done_a;

   logic [7:0] data_in_b = 8'h00;
   logic       load_valid_b = 1'b0;
   logic       load_ready_b, sout_b, busy_b, done_b;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_dut_a (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in_a),
      .load_valid (load_valid_a),
      .load_ready (load_ready_a),
      .sout       (sout_a),
      .busy       (busy_a),
      .done       (done_a)
   );

   serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) u_dut_b (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in_b),
      .load_valid (load_valid_b),
      .load_ready (load_ready_b),
      .sout       (sout_b),
      .busy       (busy_b),
      .done       (done_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offer a word to A for exactly one accepting edge, then drive 'after' on data_in.
   task automatic send_a(input logic [7:0] d, input logic [7:0] after);
      @(negedge clk);
      data_in_a    = d;
      load_valid_a = 1'b1;
      @(posedge clk);
      #1;
      load_valid_a = 1'b0;
      data_in_a    = after;
   endtask

   // Find A's start bit, then check every cycle of an 11-bit frame and the done cycle.
   task automatic check_frame_a(input logic [10:0] pat, input string tag,
                                input bit need_immediate, input bit drop_valid);
      int waits = 0;
      do begin
         @(negedge clk);
         waits++;
      end while (sout_a !== 1'b0 && waits < 200);
      check({tag, "_start"}, {31'd0, sout_a}, 32'd0);
      if (need_immediate) check({tag, "_gap"}, waits, 32'd1);
      if (drop_valid) load_valid_a = 1'b0;
      for (int b = 0; b < 11; b++) begin
         for (int c = 0; c < 4; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            check($sformatf("%s_b%0d_c%0d_sout", tag, b, c), {31'd0, sout_a}, {31'd0, pat[b]});
            check($sformatf("%s_b%0d_c%0d_busy", tag, b, c), {31'd0, busy_a}, 32'd1);
            check($sformatf("%s_b%0d_c%0d_rdy", tag, b, c), {31'd0, load_ready_a}, 32'd0);
            check($sformatf("%s_b%0d_c%0d_done", tag, b, c), {31'd0, done_a}, 32'd0);
         end
      end
      @(negedge clk);
      check({tag, "_done"}, {31'd0, done_a}, 32'd1);
      check({tag, "_idle_busy"}, {31'd0, busy_a}, 32'd0);
      check({tag, "_idle_sout"}, {31'd0, sout_a}, 32'd1);
      check({tag, "_idle_rdy"}, {31'd0, load_ready_a}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [9:0] pat_b;
      int waits;

      // Reset asserted between edges, released between edges, no load.
      #2 rst = 1'b0;
      #1;
      check("rst_sout_a", {31'd0, sout_a}, 32'd1);
      check("rst_busy_a", {31'd0, busy_a}, 32'd0);
      check("rst_done_a", {31'd0, done_a}, 32'd0);
      check("rst_rdy_a", {31'd0, load_ready_a}, 32'd1);
      check("rst_sout_b", {31'd0, sout_b}, 32'd1);
      #4 rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle_sout_a", {31'd0, sout_a}, 32'd1);
         check("idle_busy_a", {31'd0, busy_a}, 32'd0);
         check("idle_done_a", {31'd0, done_a}, 32'd0);
         check("idle_rdy_a", {31'd0, load_ready_a}, 32'd1);
      end

      // Single frames on A.
      send_a(8'hA5, 8'h00);
      check_frame_a(11'b1_0_10100101_0, "a5", 1'b1, 1'b0);
      send_a(8'h07, 8'h00);
      check_frame_a(11'b1_1_00000111_0, "x07", 1'b1, 1'b0);

      // Instance B: one clock per bit, no parity, 8'h01.
      pat_b = 10'b1_00000001_0;
      @(negedge clk);
      data_in_b    = 8'h01;
      load_valid_b = 1'b1;
      @(posedge clk);
      #1 load_valid_b = 1'b0;
      waits = 0;
      do begin
         @(negedge clk);
         waits++;
      end while (sout_b !== 1'b0 && waits < 50);
      check("b_gap", waits, 32'd1);
      for (int b = 0; b < 10; b++) begin
         if (b != 0) @(negedge clk);
         check($sformatf("b_bit%0d", b), {31'd0, sout_b}, {31'd0, pat_b[b]});
         check($sformatf("b_done%0d", b), {31'd0, done_b}, 32'd0);
      end
      @(negedge clk);
      check("b_done", {31'd0, done_b}, 32'd1);
      check("b_busy_end", {31'd0, busy_b}, 32'd0);
      @(negedge clk);
      check("b_done_once", {31'd0, done_b}, 32'd0);

      // Back-to-back frames with load_valid held high.
      @(negedge clk);
      data_in_a    = 8'h0F;
      load_valid_a = 1'b1;
      @(posedge clk);
      #1 data_in_a = 8'hF0;
      check_frame_a(11'b1_0_00001111_0, "b2b0", 1'b1, 1'b0);
      check_frame_a(11'b1_0_11110000_0, "b2b1", 1'b1, 1'b1);

      // Data changed right after acceptance must not affect the frame.
      send_a(8'h3C, 8'hFF);
      check_frame_a(11'b1_0_00111100_0, "x3c", 1'b1, 1'b0);

      // Reset mid-frame while a zero data bit is on the line.
      send_a(8'hA5, 8'h00);
      waits = 0;
      do begin
         @(negedge clk);
         waits++;
      end while (sout_a !== 1'b0 && waits < 50);
      repeat (9) @(negedge clk);
      check("mid_pre_sout", {31'd0, sout_a}, 32'd0);
      check("mid_pre_busy", {31'd0, busy_a}, 32'd1);
      #1 rst = 1'b0;
      #1;
      check("mid_rst_sout", {31'd0, sout_a}, 32'd1);
      check("mid_rst_busy", {31'd0, busy_a}, 32'd0);
      check("mid_rst_done", {31'd0, done_a}, 32'd0);
      check("mid_rst_rdy", {31'd0, load_ready_a}, 32'd1);
      #6 rst = 1'b1;
      @(negedge clk);
      check("mid_after_sout", {31'd0, sout_a}, 32'd1);
      check("mid_after_busy", {31'd0, busy_a}, 32'd0);
      send_a(8'h55, 8'h00);
      check_frame_a(11'b1_0_01010101_0, "x55", 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
